// File: rtl/credit_pipelined_trigger.sv
// -----------------------------------------------------------------------------
// credit_pipelined_trigger
//
// Actor trigger that launches one HLS actor in pipelined fashion with a bounded
// number of in-flight invocations (credits). When the actor and all sibling
// triggers report "waited", the trigger drains its in-flight work, then runs
// the sleep / sync-sleep termination protocol together with its siblings.
//
// Handshake (actor side): an invocation is accepted on any cycle where
// actor_start and actor_ready are both high. actor_start never depends on
// actor_ready. Each actor_done pulse retires exactly one accepted invocation,
// and actor_return is valid only while actor_done is high.
//
// Ports
//   ap_clk, ap_rst        clock, synchronous active-high reset
//   ap_start              network start request (ignored unless idle)
//   ap_done / ap_ready    one-cycle pulse as the trigger returns to idle
//   ap_idle               trigger is idle
//   all_sleep             AND of every trigger's sleep
//   all_sync_sleep        AND of every trigger's sync_sleep
//   all_waited            AND of every trigger's waited
//   sleep, sync_sleep     this trigger's termination-protocol status
//   waited                last actor_done returned WAIT_CODE
//   actor_return          actor return value (valid with actor_done)
//   actor_done            actor invocation completed
//   actor_ready           actor accepted actor_start this cycle
//   actor_idle            actor idle status (monitor only)
//   actor_start           launch request to the actor
//   inflight              accepted-but-not-done invocation count
//   launch_count          accepted launches since the last start from idle
//   protocol_error        sticky: actor_done seen with nothing in flight
//   dbg_state_o           current FSM state encoding
// -----------------------------------------------------------------------------
module credit_pipelined_trigger #(
  parameter int              MAX_INFLIGHT = 4,
  parameter int              CNT_W        = $clog2(MAX_INFLIGHT + 1),
  parameter int              RET_W        = 2,
  parameter logic [RET_W-1:0] WAIT_CODE   = 2'd1,
  parameter int              LCNT_W       = 32
) (
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic              ap_start,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  input  logic              all_sleep,
  input  logic              all_sync_sleep,
  input  logic              all_waited,
  output logic              sleep,
  output logic              sync_sleep,
  output logic              waited,
  input  logic [RET_W-1:0]  actor_return,
  input  logic              actor_done,
  input  logic              actor_ready,
  input  logic              actor_idle,
  output logic              actor_start,
  output logic [CNT_W-1:0]  inflight,
  output logic [LCNT_W-1:0] launch_count,
  output logic              protocol_error,
  output logic [2:0]        dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_LAUNCH      = 3'd1,
    S_FLUSH       = 3'd2,
    S_SLEEP       = 3'd3,
    S_SYNC_LAUNCH = 3'd4,
    S_SYNC_SLEEP  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    inflight_q, inflight_d;
  logic [LCNT_W-1:0]   lcnt_q, lcnt_d;
  logic                waited_q, waited_d;
  logic                error_q, error_d;
  logic                ap_done_q, ap_done_d;
  logic                sync_issued_q, sync_issued_d;

  logic                start;
  logic                accept;
  logic                is_wait_ret;
  logic                wait_ev;
  logic                relaunch;

  // actor_idle is informational only; nothing in the control path uses it.
  logic                unused_actor_idle;
  assign unused_actor_idle = actor_idle;

  // ---------------------------------------------------------------------------
  // Launch request: derived from registered state and registered in-flight
  // count only, so a credit freed by actor_done is reused on the next cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    start = 1'b0;
    case (state_q)
      S_LAUNCH:      start = (inflight_q < MAX_CNT);
      S_SYNC_LAUNCH: start = (inflight_q == '0) && !sync_issued_q;
      default:       start = 1'b0;
    endcase
  end

  assign accept      = start && actor_ready;
  assign is_wait_ret = (actor_return == WAIT_CODE);
  assign wait_ev     = actor_done && is_wait_ret && all_waited;
  assign relaunch    = actor_done && !wait_ev;

  // ---------------------------------------------------------------------------
  // In-flight credit counter and sticky protocol error. A done with nothing
  // in flight is an actor protocol violation: the counter holds at zero
  // instead of wrapping. Accept and done together leave the count unchanged.
  // ---------------------------------------------------------------------------
  always_comb begin
    inflight_d = inflight_q;
    error_d    = error_q;
    if (actor_done && (inflight_q == '0)) begin
      error_d = 1'b1;
    end
    case ({accept, actor_done})
      2'b10: if (inflight_q != MAX_CNT) inflight_d = inflight_q + CNT_W'(1);
      2'b01: if (inflight_q != '0)      inflight_d = inflight_q - CNT_W'(1);
      default: inflight_d = inflight_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (ap_start) state_d = S_LAUNCH;
      end
      S_LAUNCH: begin
        if (wait_ev) state_d = (inflight_d == '0) ? S_SLEEP : S_FLUSH;
      end
      S_FLUSH: begin
        // A non-wait completion restarts launching even if it also drained
        // the last credit.
        if (relaunch)                state_d = S_LAUNCH;
        else if (inflight_d == '0)   state_d = S_SLEEP;
      end
      S_SLEEP: begin
        if (all_sleep)        state_d = S_SYNC_LAUNCH;
        else if (!all_waited) state_d = S_LAUNCH;
      end
      S_SYNC_LAUNCH: begin
        // Only the completion of the single sync launch moves us on.
        if (sync_issued_q && actor_done) state_d = S_SYNC_SLEEP;
      end
      S_SYNC_SLEEP: begin
        if (all_sync_sleep) state_d = all_waited ? S_IDLE : S_LAUNCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Side registers
  // ---------------------------------------------------------------------------
  always_comb begin
    lcnt_d = lcnt_q;
    if ((state_q == S_IDLE) && (state_d == S_LAUNCH)) begin
      lcnt_d = '0;
    end else if (accept && (lcnt_q != {LCNT_W{1'b1}})) begin
      lcnt_d = lcnt_q + LCNT_W'(1);
    end
  end

  always_comb begin
    waited_d = waited_q;
    if (actor_done) waited_d = is_wait_ret;
  end

  always_comb begin
    sync_issued_d = sync_issued_q;
    if (state_d != S_SYNC_LAUNCH) begin
      sync_issued_d = 1'b0;
    end else if ((state_q == S_SYNC_LAUNCH) && accept) begin
      sync_issued_d = 1'b1;
    end
  end

  // Registered so the pulse coincides with the first cycle back in IDLE.
  assign ap_done_d = (state_q == S_SYNC_SLEEP) && all_sync_sleep && all_waited;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q       <= S_IDLE;
      inflight_q    <= '0;
      lcnt_q        <= '0;
      waited_q      <= 1'b0;
      error_q       <= 1'b0;
      ap_done_q     <= 1'b0;
      sync_issued_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      inflight_q    <= inflight_d;
      lcnt_q        <= lcnt_d;
      waited_q      <= waited_d;
      error_q       <= error_d;
      ap_done_q     <= ap_done_d;
      sync_issued_q <= sync_issued_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign ap_idle        = (state_q == S_IDLE);
  assign ap_done        = ap_done_q;
  assign ap_ready       = ap_done_q;
  assign sleep          = (state_q == S_SLEEP) || (state_q == S_IDLE);
  assign sync_sleep     = (state_q == S_SYNC_SLEEP) || (state_q == S_IDLE);
  assign waited         = waited_q;
  assign actor_start    = start;
  assign inflight       = inflight_q;
  assign launch_count   = lcnt_q;
  assign protocol_error = error_q;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_credit_pipelined_trigger.sv
// -----------------------------------------------------------------------------
// tb_credit_pipelined_trigger
//
// Directed scenarios followed by a randomized run. A cycle-level reference
// model of the trigger's rules predicts every output each cycle. A narrow
// launch counter is used so saturation is reachable.
// -----------------------------------------------------------------------------
module tb_credit_pipelined_trigger;

  localparam int              MAX_INFL = 4;
  localparam int              CW       = $clog2(MAX_INFL + 1);
  localparam int              RW       = 2;
  localparam logic [RW-1:0]   WAIT_RET = 2'd1;
  localparam int              LW       = 4;
  localparam int              LMAX     = (1 << LW) - 1;

  // model phases
  localparam int P_IDLE = 0, P_LAUNCH = 1, P_FLUSH = 2, P_SLEEP = 3,
                 P_SYNC_LAUNCH = 4, P_SYNC_SLEEP = 5;

  // ---------------------------------------------------------------- clock/reset
  logic ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  logic          ap_rst, ap_start;
  logic          ap_done, ap_idle, ap_ready;
  logic          all_sleep, all_sync_sleep, all_waited;
  logic          sleep, sync_sleep, waited;
  logic [RW-1:0] actor_return;
  logic          actor_done, actor_ready, actor_idle, actor_start;
  logic [CW-1:0] inflight;
  logic [LW-1:0] launch_count;
  logic          protocol_error;
  logic [2:0]    dbg_state;

  credit_pipelined_trigger #(
    .MAX_INFLIGHT (MAX_INFL),
    .RET_W        (RW),
    .WAIT_CODE    (WAIT_RET),
    .LCNT_W       (LW)
  ) dut (
    .ap_clk         (ap_clk),
    .ap_rst         (ap_rst),
    .ap_start       (ap_start),
    .ap_done        (ap_done),
    .ap_idle        (ap_idle),
    .ap_ready       (ap_ready),
    .all_sleep      (all_sleep),
    .all_sync_sleep (all_sync_sleep),
    .all_waited     (all_waited),
    .sleep          (sleep),
    .sync_sleep     (sync_sleep),
    .waited         (waited),
    .actor_return   (actor_return),
    .actor_done     (actor_done),
    .actor_ready    (actor_ready),
    .actor_idle     (actor_idle),
    .actor_start    (actor_start),
    .inflight       (inflight),
    .launch_count   (launch_count),
    .protocol_error (protocol_error),
    .dbg_state_o    (dbg_state)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_vec;
  int n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  int m_phase;
  int m_infl;
  bit m_waited;
  int m_lcnt;
  bit m_err;
  bit m_done;
  int m_sync_cnt;   // sync launches accepted during the current sync-launch visit

  function automatic bit m_start();
    if (m_phase == P_LAUNCH)      return m_infl < MAX_INFL;
    if (m_phase == P_SYNC_LAUNCH) return (m_infl == 0) && (m_sync_cnt == 0);
    return 1'b0;
  endfunction

  task automatic model_step();
    bit acc, wev, rel;
    int ni, np;
    if (ap_rst) begin
      m_phase = P_IDLE; m_infl = 0; m_waited = 0; m_lcnt = 0;
      m_err = 0; m_done = 0; m_sync_cnt = 0;
      return;
    end
    acc = m_start() && actor_ready;
    wev = actor_done && (actor_return == WAIT_RET) && all_waited;
    rel = actor_done && !wev;
    ni  = m_infl + int'(acc) - int'(actor_done);
    if (ni < 0) ni = 0;
    if (actor_done && m_infl == 0) m_err = 1;
    if (actor_done) m_waited = (actor_return == WAIT_RET);
    m_done = (m_phase == P_SYNC_SLEEP) && all_sync_sleep && all_waited;
    np = m_phase;
    case (m_phase)
      P_IDLE:        if (ap_start) np = P_LAUNCH;
      P_LAUNCH:      if (wev) np = (ni == 0) ? P_SLEEP : P_FLUSH;
      P_FLUSH:       if (rel) np = P_LAUNCH; else if (ni == 0) np = P_SLEEP;
      P_SLEEP:       if (all_sleep) np = P_SYNC_LAUNCH; else if (!all_waited) np = P_LAUNCH;
      P_SYNC_LAUNCH: if (actor_done && m_sync_cnt > 0) np = P_SYNC_SLEEP;
      P_SYNC_SLEEP:  if (all_sync_sleep) np = all_waited ? P_IDLE : P_LAUNCH;
      default:       np = P_IDLE;
    endcase
    if (m_phase == P_IDLE && np == P_LAUNCH) m_lcnt = 0;
    else if (acc && m_lcnt < LMAX)           m_lcnt++;
    if (np != P_SYNC_LAUNCH) m_sync_cnt = 0;
    else if (acc)            m_sync_cnt++;
    m_phase = np;
    m_infl  = ni;
  endtask

  task automatic check_outputs();
    check("ap_idle",        ap_idle,        m_phase == P_IDLE);
    check("sleep",          sleep,          m_phase == P_IDLE || m_phase == P_SLEEP);
    check("sync_sleep",     sync_sleep,     m_phase == P_IDLE || m_phase == P_SYNC_SLEEP);
    check("waited",         waited,         m_waited);
    check("actor_start",    actor_start,    m_start());
    check("inflight",       inflight,       m_infl);
    check("launch_count",   launch_count,   m_lcnt);
    check("protocol_error", protocol_error, m_err);
    check("ap_done",        ap_done,        m_done);
    check("ap_ready",       ap_ready,       m_done);
  endtask

  // ---------------------------------------------------------------- driver tasks
  // Inputs are held from just after a rising edge; outputs are compared on
  // the falling edge, then the model consumes the same inputs.
  task automatic run_cycle();
    @(negedge ap_clk);
    check_outputs();
    model_step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic clear_inputs();
    ap_rst = 0; ap_start = 0; all_sleep = 0; all_sync_sleep = 0; all_waited = 0;
    actor_return = '0; actor_done = 0; actor_ready = 0; actor_idle = 0;
  endtask

  task automatic drive_random();
    ap_rst         = ($urandom_range(0, 199) == 0);
    ap_start       = ($urandom_range(0, 3) == 0);
    actor_ready    = ($urandom_range(0, 9) < 7);
    actor_done     = (m_infl > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 59) == 0);
    actor_return   = ($urandom_range(0, 1) == 1) ? WAIT_RET : RW'($urandom_range(0, 3));
    all_waited     = ($urandom_range(0, 9) < 6);
    all_sleep      = ($urandom_range(0, 1) == 1);
    all_sync_sleep = ($urandom_range(0, 1) == 1);
    actor_idle     = ($urandom_range(0, 1) == 1);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    n_vec = 0;
    n_err = 0;
    clear_inputs();
    ap_rst = 1;
    @(posedge ap_clk);
    #1;
    model_step();
    run_cycle();
    ap_rst = 0;
    check("rst_idle",     ap_idle,     1);
    check("rst_inflight", inflight,    0);
    check("rst_start",    actor_start, 0);

    // credit limit: continuous ready, no completions
    ap_start = 1; run_cycle(); ap_start = 0;
    actor_ready = 1;
    repeat (6) run_cycle();
    check("credit_inflight", inflight,     4);
    check("credit_start",    actor_start,  0);
    check("credit_lcnt",     launch_count, 4);

    // launch counter saturation with a steady done/refill stream
    actor_done = 1; actor_return = 2'd0;
    repeat (20) run_cycle();
    check("sat_lcnt",     launch_count, LMAX);
    check("sat_inflight", inflight,     3);

    // wait completion with all waited -> flush, then drain to sleep
    actor_ready = 0; actor_return = WAIT_RET; all_waited = 1;
    run_cycle();
    check("flush_start",    actor_start, 0);
    check("flush_inflight", inflight,    2);
    repeat (2) run_cycle();
    actor_done = 0;
    check("drain_sleep",    sleep,    1);
    check("drain_inflight", inflight, 0);
    check("drain_waited",   waited,   1);

    // sync launch, sync sleep, completion pulse
    all_sleep = 1; run_cycle(); all_sleep = 0;
    check("sync_start", actor_start, 1);
    actor_ready = 1; run_cycle(); actor_ready = 0;
    check("sync_one_only", actor_start, 0);
    check("sync_inflight", inflight,    1);
    actor_done = 1; actor_return = 2'd0; run_cycle(); actor_done = 0;
    check("ssleep_flag", sync_sleep, 1);
    check("ssleep_busy", ap_idle,    0);
    all_sync_sleep = 1; run_cycle(); all_sync_sleep = 0;
    check("done_pulse", ap_done,  1);
    check("done_ready", ap_ready, 1);
    check("done_idle",  ap_idle,  1);
    run_cycle();
    check("done_single", ap_done, 0);

    // spurious completion while idle
    actor_done = 1; run_cycle(); actor_done = 0;
    check("err_set",      protocol_error, 1);
    check("err_inflight", inflight,       0);
    repeat (3) run_cycle();
    check("err_sticky", protocol_error, 1);

    // reset in the middle of launching
    ap_start = 1; run_cycle(); ap_start = 0;
    actor_ready = 1; repeat (3) run_cycle(); actor_ready = 0;
    check("pre_rst_inflight", inflight, 3);
    ap_rst = 1; run_cycle(); ap_rst = 0;
    check("mid_rst_idle",     ap_idle,        1);
    check("mid_rst_inflight", inflight,       0);
    check("mid_rst_start",    actor_start,    0);
    check("mid_rst_error",    protocol_error, 0);

    // non-wait completion during flush resumes launching
    ap_start = 1; run_cycle(); ap_start = 0;
    actor_ready = 1; repeat (2) run_cycle(); actor_ready = 0;
    actor_done = 1; actor_return = WAIT_RET; run_cycle();
    check("flush2_start", actor_start, 0);
    actor_return = 2'd0; run_cycle(); actor_done = 0;
    check("relaunch_start", actor_start,  1);
    check("relaunch_lcnt",  launch_count, 2);
    actor_ready = 1; run_cycle(); actor_ready = 0;
    check("relaunch_lcnt2", launch_count, 3);

    // randomized run against the model
    for (int i = 0; i < 4000; i++) begin
      drive_random();
      run_cycle();
    end
    clear_inputs();
    run_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
